// File: rtl/ponylink_stream_checker.sv
// rtl/ponylink_stream_checker.sv - PonyLink ramp-pattern receive checker with lock FSM and error counters.
// Optional macro PONYLINK_CHECKER_STRETCH_EN stretches error_led over STRETCH_CYCLES clocks.
`timescale 1ns/1ps
module ponylink_stream_checker #(
  parameter int                     TDATA_WIDTH    = 16,
  parameter int                     UP_STEP        = 2,
  parameter int                     DOWN_STEP      = 5,
  parameter logic [TDATA_WIDTH-1:0] LOW_THRESH     = 16'h4000,
  parameter logic [TDATA_WIDTH-1:0] HIGH_THRESH    = 16'hc000,
  parameter int                     LOCK_COUNT     = 4,
  parameter int                     LOSS_COUNT     = 3,
  parameter int                     ERRCNT_WIDTH   = 16,
  parameter int                     STRETCH_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic [TDATA_WIDTH-1:0]  in_tdata,
  input  logic                    in_tvalid,
  input  logic                    in_tlast,
  output logic                    in_tready,
  output logic                    mode,
  output logic                    locked,
  output logic                    error_pulse,
  output logic [ERRCNT_WIDTH-1:0] error_count,
  output logic [31:0]             word_count,
  output logic                    error_led
);

  localparam int RUN_W = 8;
  localparam logic [RUN_W-1:0]       LOCK_N = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0]       LOSS_N = RUN_W'(LOSS_COUNT);
  localparam logic [TDATA_WIDTH-1:0] UP_D   = TDATA_WIDTH'(UP_STEP);
  localparam logic [TDATA_WIDTH-1:0] DOWN_D = TDATA_WIDTH'(-DOWN_STEP);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic                   first_q;
  logic [TDATA_WIDTH-1:0] prev_q;
  logic [RUN_W-1:0]       good_run_q, good_run_d;
  logic [RUN_W-1:0]       bad_run_q, bad_run_d;
  logic                   bad_err;

  logic                   accept;
  logic                   checked;
  logic [TDATA_WIDTH-1:0] delta;
  logic                   good_delta;

  assign accept     = in_tvalid && in_tready;
  assign checked    = accept && !first_q;
  assign delta      = in_tdata - prev_q;
  assign good_delta = (delta == UP_D) || (delta == DOWN_D);
  assign locked     = (state_q == LOCKED);

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    bad_run_d  = bad_run_q;
    bad_err    = 1'b0;
    if (checked) begin
      case (state_q)
        HUNT: begin
          if (!good_delta) begin
            good_run_d = '0;
          end else if (good_run_q + 8'd1 == LOCK_N) begin
            state_d    = LOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
          end else begin
            good_run_d = good_run_q + 8'd1;
          end
        end
        LOCKED: begin
          if (good_delta) begin
            bad_run_d = '0;
          end else begin
            // Only errors seen while locked are reported and counted.
            bad_err = 1'b1;
            if (bad_run_q + 8'd1 == LOSS_N) begin
              state_d    = HUNT;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              bad_run_d = bad_run_q + 8'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= HUNT;
      first_q     <= 1'b1;
      prev_q      <= '0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      in_tready   <= 1'b0;
      mode        <= 1'b0;
      error_pulse <= 1'b0;
      error_count <= '0;
      word_count  <= '0;
    end else begin
      in_tready   <= 1'b1;
      state_q     <= state_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      error_pulse <= bad_err;
      if (accept) begin
        prev_q  <= in_tdata;
        first_q <= in_tlast;
        if (in_tdata < LOW_THRESH) begin
          mode <= 1'b0;
        end else if (in_tdata >= HIGH_THRESH) begin
          mode <= 1'b1;
        end
      end
      if (clear) begin
        error_count <= '0;
        word_count  <= '0;
      end else begin
        if (accept) begin
          word_count <= word_count + 32'd1;
        end
        if (bad_err && (error_count != '1)) begin
          error_count <= error_count + 1'b1;
        end
      end
    end
  end

`ifdef PONYLINK_CHECKER_STRETCH_EN
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  logic [SW-1:0] stretch_q;

  // Each new error reloads the full hold time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stretch_q <= '0;
    end else if (error_pulse) begin
      stretch_q <= SW'(STRETCH_CYCLES);
    end else if (stretch_q != '0) begin
      stretch_q <= stretch_q - 1'b1;
    end
  end

  assign error_led = (stretch_q != '0);
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      error_led <= 1'b0;
    end else begin
      error_led <= error_pulse;
    end
  end
`endif

endmodule

// File: tb/tb_ponylink_stream_checker.sv
// tb/tb_ponylink_stream_checker.sv - directed bench with a behavioural model for ponylink_stream_checker.
`timescale 1ns/1ps
module tb_ponylink_stream_checker;

  logic        clk;
  logic        resetn;
  logic        clear;
  logic [15:0] in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic        mode;
  logic        locked;
  logic        error_pulse;
  logic [15:0] error_count;
  logic [31:0] word_count;
  logic        error_led;

  ponylink_stream_checker dut (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (clear),
    .in_tdata    (in_tdata),
    .in_tvalid   (in_tvalid),
    .in_tlast    (in_tlast),
    .in_tready   (in_tready),
    .mode        (mode),
    .locked      (locked),
    .error_pulse (error_pulse),
    .error_count (error_count),
    .word_count  (word_count),
    .error_led   (error_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model of the checker: what every output must read after the coming edge.
  logic        exp_ready, exp_mode, exp_locked, exp_pulse, exp_led;
  logic [15:0] exp_errs;
  logic [31:0] exp_words;
  logic [15:0] m_prev;
  logic        m_first;
  int          m_good, m_bad;

  task automatic model_reset();
    exp_ready = 0; exp_mode = 0; exp_locked = 0; exp_pulse = 0; exp_led = 0;
    exp_errs = 0; exp_words = 0; m_prev = 0; m_first = 1; m_good = 0; m_bad = 0;
  endtask

  task automatic model_step(input logic v, input logic [15:0] d, input logic l, input logic c);
    logic        acc;
    logic [15:0] delta;
    logic        good;
    logic        pulse;
    if (!resetn) begin
      model_reset();
    end else begin
      exp_led   = exp_pulse;
      acc       = v && exp_ready;
      exp_ready = 1;
      pulse     = 0;
      if (acc) begin
        if (!m_first) begin
          delta = d - m_prev;
          good  = (delta == 16'd2) || (delta == 16'hfffb);
          if (exp_locked) begin
            if (good) m_bad = 0;
            else begin
              pulse = 1;
              m_bad++;
              if (m_bad == 3) begin exp_locked = 0; m_good = 0; m_bad = 0; end
            end
          end else begin
            if (good) begin
              m_good++;
              if (m_good == 4) begin exp_locked = 1; m_good = 0; m_bad = 0; end
            end else m_good = 0;
          end
        end
        m_prev  = d;
        m_first = l;
        exp_words = exp_words + 1;
        if (d < 16'h4000) exp_mode = 0;
        else if (d >= 16'hc000) exp_mode = 1;
      end
      exp_pulse = pulse;
      if (pulse && exp_errs != 16'hffff) exp_errs = exp_errs + 1;
      if (c) begin exp_errs = 0; exp_words = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("in_tready", {31'd0, in_tready}, {31'd0, exp_ready});
    chk("mode", {31'd0, mode}, {31'd0, exp_mode});
    chk("locked", {31'd0, locked}, {31'd0, exp_locked});
    chk("error_pulse", {31'd0, error_pulse}, {31'd0, exp_pulse});
    chk("error_count", {16'd0, error_count}, {16'd0, exp_errs});
    chk("word_count", word_count, exp_words);
    chk("error_led", {31'd0, error_led}, {31'd0, exp_led});
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic l, input logic c);
    in_tvalid = v; in_tdata = d; in_tlast = l; clear = c;
    model_step(v, d, l, c);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    cycle(1'b1, d, l, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    vectors = 0; miscompares = 0;
    resetn = 0; clear = 0; in_tdata = 0; in_tvalid = 0; in_tlast = 0;
    model_reset();
    cycle(1'b1, 16'h0, 1'b0, 1'b0);
    idle();
    chk("reset_ready", {31'd0, in_tready}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    resetn = 1;
    idle();
    chk("ready_after_reset", {31'd0, in_tready}, 32'd1);

    // Lock on up-ramp.
    send(16'd0, 0); send(16'd2, 0); send(16'd4, 0); send(16'd6, 0);
    chk("not_yet_locked", {31'd0, locked}, 32'd0);
    send(16'd8, 0);
    chk("lock_locked", {31'd0, locked}, 32'd1);
    chk("lock_errs", {16'd0, error_count}, 32'd0);
    chk("lock_words", word_count, 32'd5);

    // Direction change and mode hysteresis.
    send(16'd10, 1);
    for (int u = 'hbff0; u <= 'hc004; u += 2) begin
      send(16'(u), 0);
      if (u == 'hbffe) chk("mode_below_high", {31'd0, mode}, 32'd0);
      if (u == 'hc000) chk("mode_set", {31'd0, mode}, 32'd1);
    end
    d = 16'hc004;
    for (int k = 0; k < 7000; k++) begin
      d = d - 16'd5;
      send(d, 0);
      if (d == 16'h4002) chk("mode_held", {31'd0, mode}, 32'd1);
      if (d < 16'h4000) break;
    end
    chk("mode_cleared", {31'd0, mode}, 32'd0);
    chk("ramp_errs", {16'd0, error_count}, 32'd0);

    // Single bad word while locked.
    send(16'h3ff8, 1);
    send(16'd100, 0); send(16'd102, 0); send(16'd104, 0); send(16'd106, 0); send(16'd108, 0);
    send(16'd200, 0);
    chk("single_pulse", {31'd0, error_pulse}, 32'd1);
    chk("single_errs", {16'd0, error_count}, 32'd1);
    chk("single_locked", {31'd0, locked}, 32'd1);
    send(16'd202, 0);
    chk("single_led", {31'd0, error_led}, 32'd1);
    chk("single_pulse_gone", {31'd0, error_pulse}, 32'd0);

    // Lock loss and relock.
    send(16'd209, 0); send(16'd216, 0);
    chk("loss_still_locked", {31'd0, locked}, 32'd1);
    send(16'd223, 0);
    chk("loss_unlocked", {31'd0, locked}, 32'd0);
    chk("loss_errs", {16'd0, error_count}, 32'd4);
    send(16'd225, 0); send(16'd227, 0); send(16'd229, 0);
    chk("relock_pending", {31'd0, locked}, 32'd0);
    send(16'd231, 0);
    chk("relock", {31'd0, locked}, 32'd1);

    // Wrap-around and tlast.
    send(16'd233, 1);
    send(16'hfffd, 0); send(16'hffff, 0); send(16'h0001, 0);
    send(16'h0003, 1); send(16'h1234, 0);
    idle();
    send(16'h1236, 0);
    chk("wrap_errs", {16'd0, error_count}, 32'd4);
    chk("wrap_locked", {31'd0, locked}, 32'd1);

    // Clear colliding with a bad beat.
    cycle(1'b1, 16'h5000, 1'b0, 1'b1);
    chk("clear_pulse", {31'd0, error_pulse}, 32'd1);
    chk("clear_errs", {16'd0, error_count}, 32'd0);
    chk("clear_words", word_count, 32'd0);
    idle();
    chk("clear_led", {31'd0, error_led}, 32'd1);
    send(16'h5002, 0); send(16'h5004, 0);

    // Asynchronous reset mid-stream.
    #2 resetn = 0;
    #1;
    chk("arst_ready", {31'd0, in_tready}, 32'd0);
    chk("arst_mode", {31'd0, mode}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_pulse", {31'd0, error_pulse}, 32'd0);
    chk("arst_errs", {16'd0, error_count}, 32'd0);
    chk("arst_words", word_count, 32'd0);
    chk("arst_led", {31'd0, error_led}, 32'd0);
    model_reset();
    idle(); idle();
    resetn = 1;
    cycle(1'b1, 16'h0999, 1'b0, 1'b0);
    chk("not_ready_no_accept", word_count, 32'd0);
    send(16'h0777, 0);
    chk("post_reset_first", {31'd0, error_pulse}, 32'd0);
    chk("post_reset_words", word_count, 32'd1);
    send(16'h0779, 0); send(16'h0900, 0);
    chk("hunt_bad_uncounted", {16'd0, error_count}, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
